// File: rtl/psum_accumulate_drain_pkg.sv
// -----------------------------------------------------------------------------
// psum_accumulate_drain_pkg
// Shared constants and FSM state encodings for the partial-sum accumulate/drain
// block and its drain serializer.
//   TN               lanes per captured kernel_sum vector
//   FEATURE_WIDTH    signed lane width of inputs and drained results
//   PSUM_ACC_WIDTH   signed accumulator width per lane
//   PSUM_RND_WIDTH   width of the rounds configuration
//   PSUM_PROD_WIDTH  width wide enough for acc * unsigned 16-bit scale
// -----------------------------------------------------------------------------
package psum_accumulate_drain_pkg;

    localparam int unsigned TN              = 4;
    localparam int unsigned FEATURE_WIDTH   = 16;
    localparam int unsigned PSUM_ACC_WIDTH  = 32;
    localparam int unsigned PSUM_RND_WIDTH  = 8;
    localparam int unsigned LANE_WIDTH      = (TN > 1) ? $clog2(TN) : 1;
    localparam int unsigned PSUM_PROD_WIDTH = PSUM_ACC_WIDTH + 17;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_e;

    typedef enum logic {
        DRN_EMPTY = 1'b0,
        DRN_FULL  = 1'b1
    } drn_state_e;

endpackage

// File: rtl/psum_drain_serializer.sv
// -----------------------------------------------------------------------------
// psum_drain_serializer
// Holds one saturated TN-lane vector and streams it out one lane per cycle over
// a valid/ready handshake, lane 0 first.
// Ports:
//   i_fast_clk   clock
//   i_rst        asynchronous reset, active-low
//   i_load       load i_load_data into the buffer (only issued while empty)
//   i_load_data  TN x FEATURE_WIDTH packed lanes, lane i at [(i+1)*FW-1 : i*FW]
//   i_out_ready  downstream accepts the current lane
//   o_full       buffer holds a vector not yet fully drained
//   o_out_valid  o_out_data valid
//   o_out_data   current lane value
//   o_out_lane   current lane index
//   o_out_last   high with the last lane
// -----------------------------------------------------------------------------
module psum_drain_serializer
    import psum_accumulate_drain_pkg::*;
(
    input  logic                          i_fast_clk,
    input  logic                          i_rst,
    input  logic                          i_load,
    input  logic [TN*FEATURE_WIDTH-1:0]   i_load_data,
    input  logic                          i_out_ready,
    output logic                          o_full,
    output logic                          o_out_valid,
    output logic [FEATURE_WIDTH-1:0]      o_out_data,
    output logic [LANE_WIDTH-1:0]         o_out_lane,
    output logic                          o_out_last
);

    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(TN - 1);

    drn_state_e                 r_state;
    logic [LANE_WIDTH-1:0]      r_lane;
    logic [FEATURE_WIDTH-1:0]   r_buf [TN];

    always_ff @(posedge i_fast_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= DRN_EMPTY;
            r_lane  <= '0;
            for (int i = 0; i < TN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            unique case (r_state)
                DRN_EMPTY: begin
                    if (i_load) begin
                        for (int i = 0; i < TN; i++) begin
                            r_buf[i] <= i_load_data[i*FEATURE_WIDTH +: FEATURE_WIDTH];
                        end
                        r_lane  <= '0;
                        r_state <= DRN_FULL;
                    end
                end
                DRN_FULL: begin
                    if (i_out_ready) begin
                        if (r_lane == LAST_LANE) begin
                            r_lane  <= '0;
                            r_state <= DRN_EMPTY;
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                default: r_state <= DRN_EMPTY;
            endcase
        end
    end

    always_comb begin
        o_full      = (r_state == DRN_FULL);
        o_out_valid = o_full;
        o_out_data  = r_buf[r_lane];
        o_out_lane  = r_lane;
        o_out_last  = o_full && (r_lane == LAST_LANE);
    end

endmodule

// File: rtl/psum_accumulate_drain.sv
// -----------------------------------------------------------------------------
// psum_accumulate_drain
// Consumer of the TN-lane kernel adder tree. Accumulates kernel_sum vectors over
// cfg_rounds input-channel tiles, saturates the finished vector to FEATURE_WIDTH
// and hands it to psum_drain_serializer, which streams one lane per cycle.
// Optional feature macro: PSUM_SCALE_EN adds i_cfg_scale/i_cfg_shift (latched on
// start); the drain value becomes saturate((acc*scale) >>> shift) through one
// extra register stage.
// Ports:
//   i_fast_clk       clock
//   i_rst            asynchronous reset, active-low
//   i_start          pulse: clear accumulators/round counter, latch config
//   i_cfg_rounds     tiles per output vector (0 treated as 1)
//   i_sum_valid      i_kernel_sum_tn valid this cycle
//   i_kernel_sum_tn  TN signed lanes, lane i at [(i+1)*FW-1 : i*FW]
//   o_in_ready       i_sum_valid is accepted this cycle
//   o_out_valid      o_out_data valid
//   i_out_ready      downstream accepts
//   o_out_data       saturated lane result
//   o_out_lane       lane index of o_out_data
//   o_out_last       high with lane TN-1
//   o_busy           accumulation in progress or drain not empty
//   o_err_overrun    sticky: sum offered while not ready
// -----------------------------------------------------------------------------
module psum_accumulate_drain
    import psum_accumulate_drain_pkg::*;
(
    input  logic                          i_fast_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [PSUM_RND_WIDTH-1:0]     i_cfg_rounds,
`ifdef PSUM_SCALE_EN
    input  logic [15:0]                   i_cfg_scale,
    input  logic [4:0]                    i_cfg_shift,
`endif
    input  logic                          i_sum_valid,
    input  logic [TN*FEATURE_WIDTH-1:0]   i_kernel_sum_tn,
    output logic                          o_in_ready,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [FEATURE_WIDTH-1:0]      o_out_data,
    output logic [LANE_WIDTH-1:0]         o_out_lane,
    output logic                          o_out_last,
    output logic                          o_busy,
    output logic                          o_err_overrun
);

    // Clamp a wide signed value into the signed FEATURE_WIDTH range.
    function automatic logic [FEATURE_WIDTH-1:0] saturate(
        input logic signed [PSUM_PROD_WIDTH-1:0] v
    );
        logic signed [PSUM_PROD_WIDTH-1:0] hi;
        logic signed [PSUM_PROD_WIDTH-1:0] lo;
        hi = {{(PSUM_PROD_WIDTH-FEATURE_WIDTH+1){1'b0}}, {(FEATURE_WIDTH-1){1'b1}}};
        lo = {{(PSUM_PROD_WIDTH-FEATURE_WIDTH+1){1'b1}}, {(FEATURE_WIDTH-1){1'b0}}};
        if (v > hi) begin
            saturate = hi[FEATURE_WIDTH-1:0];
        end else if (v < lo) begin
            saturate = lo[FEATURE_WIDTH-1:0];
        end else begin
            saturate = v[FEATURE_WIDTH-1:0];
        end
    endfunction

    acc_state_e                         r_state;
    logic [PSUM_RND_WIDTH-1:0]          r_rounds;
    logic [PSUM_RND_WIDTH-1:0]          r_round_cnt;
    logic signed [PSUM_ACC_WIDTH-1:0]   r_acc [TN];
    logic                               r_err;

    logic signed [PSUM_ACC_WIDTH-1:0]   w_sum [TN];
    logic [TN*FEATURE_WIDTH-1:0]        w_sat_vec;
    logic                               w_last_round;
    logic                               w_drain_full;
    logic                               w_pipe_busy;
    logic                               w_in_ready;
    logic                               w_take;
    logic                               w_accept;
    logic                               w_overrun;
    logic                               w_final;
    logic                               w_drain_load;
    logic [TN*FEATURE_WIDTH-1:0]        w_drain_data;

    // Lane-wise sign-extended add of the incoming vector into the accumulators.
    always_comb begin
        for (int i = 0; i < TN; i++) begin
            w_sum[i] = r_acc[i] + {{(PSUM_ACC_WIDTH-FEATURE_WIDTH)
                                    {i_kernel_sum_tn[i*FEATURE_WIDTH+FEATURE_WIDTH-1]}},
                                   i_kernel_sum_tn[i*FEATURE_WIDTH +: FEATURE_WIDTH]};
        end
    end

`ifdef PSUM_SCALE_EN
    logic [15:0]                        r_scale;
    logic [4:0]                         r_shift;
    logic                               r_pipe_valid;
    logic [TN*FEATURE_WIDTH-1:0]        r_pipe_data;
    logic signed [PSUM_PROD_WIDTH-1:0]  w_ext_acc [TN];
    logic signed [PSUM_PROD_WIDTH-1:0]  w_prod [TN];
    logic signed [PSUM_PROD_WIDTH-1:0]  w_ext_scale;

    always_comb begin
        w_ext_scale = {{(PSUM_PROD_WIDTH-16){1'b0}}, r_scale};
        for (int i = 0; i < TN; i++) begin
            w_ext_acc[i] = {{(PSUM_PROD_WIDTH-PSUM_ACC_WIDTH){w_sum[i][PSUM_ACC_WIDTH-1]}},
                            w_sum[i]};
            w_prod[i]    = (w_ext_acc[i] * w_ext_scale) >>> r_shift;
            w_sat_vec[i*FEATURE_WIDTH +: FEATURE_WIDTH] = saturate(w_prod[i]);
        end
    end

    // Scaled result is registered once before entering the drain buffer.
    always_ff @(posedge i_fast_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_scale      <= '0;
            r_shift      <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
        end else begin
            if (i_start) begin
                r_scale <= i_cfg_scale;
                r_shift <= i_cfg_shift;
            end
            r_pipe_valid <= w_final;
            if (w_final) begin
                r_pipe_data <= w_sat_vec;
            end
        end
    end

    assign w_pipe_busy  = r_pipe_valid;
    assign w_drain_load = r_pipe_valid;
    assign w_drain_data = r_pipe_data;
`else
    always_comb begin
        for (int i = 0; i < TN; i++) begin
            w_sat_vec[i*FEATURE_WIDTH +: FEATURE_WIDTH] =
                saturate({{(PSUM_PROD_WIDTH-PSUM_ACC_WIDTH){w_sum[i][PSUM_ACC_WIDTH-1]}},
                          w_sum[i]});
        end
    end

    assign w_pipe_busy  = 1'b0;
    assign w_drain_load = w_final;
    assign w_drain_data = w_sat_vec;
`endif

    // Ready depends only on registered state, never on i_out_ready, so the final
    // round of the next vector waits until the buffer (and pipe stage) is free.
    always_comb begin
        w_last_round = (r_round_cnt == (r_rounds - PSUM_RND_WIDTH'(1)));
        w_in_ready   = !((w_drain_full || w_pipe_busy) && w_last_round);
        w_take       = (r_state == ACC_RUN) && i_sum_valid && !i_start;
        w_accept     = w_take && w_in_ready;
        w_overrun    = w_take && !w_in_ready;
        w_final      = w_accept && w_last_round;
    end

    always_ff @(posedge i_fast_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ACC_IDLE;
            r_rounds    <= PSUM_RND_WIDTH'(1);
            r_round_cnt <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < TN; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            if (i_start) begin
                // Start wins over a coincident sum and aborts any partial vector.
                r_state     <= ACC_RUN;
                r_rounds    <= (i_cfg_rounds == '0) ? PSUM_RND_WIDTH'(1) : i_cfg_rounds;
                r_round_cnt <= '0;
                for (int i = 0; i < TN; i++) begin
                    r_acc[i] <= '0;
                end
            end else if (w_overrun) begin
                r_err <= 1'b1;
            end else if (w_accept) begin
                if (w_last_round) begin
                    r_round_cnt <= '0;
                    for (int i = 0; i < TN; i++) begin
                        r_acc[i] <= '0;
                    end
                end else begin
                    r_round_cnt <= r_round_cnt + 1'b1;
                    for (int i = 0; i < TN; i++) begin
                        r_acc[i] <= w_sum[i];
                    end
                end
            end
        end
    end

    psum_drain_serializer u_serializer (
        .i_fast_clk  (i_fast_clk),
        .i_rst       (i_rst),
        .i_load      (w_drain_load),
        .i_load_data (w_drain_data),
        .i_out_ready (i_out_ready),
        .o_full      (w_drain_full),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .o_out_lane  (o_out_lane),
        .o_out_last  (o_out_last)
    );

    assign o_in_ready    = w_in_ready;
    assign o_err_overrun = r_err;
    assign o_busy        = ((r_state == ACC_RUN) && (r_round_cnt != '0)) ||
                           w_drain_full || w_pipe_busy;

endmodule
